// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, ALU-op encodings and the iterative-engine types.
// Imported by the execute-stage ALU, its iterative MUL/DIV/REM engine and the decoder.
package alu_pkg;

    // 4-bit ALU control codes produced by the ALU control decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_DIV  = 4'b1101;
    localparam logic [3:0] ALU_REM  = 4'b1110;

    // 2-bit alu_op from the main decoder to the ALU control decoder
    localparam logic [1:0] ALU_OP_LOADSTORE = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH    = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE     = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE     = 2'b11;

    // Iterative engine FSM states
    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MUL_IT  = 3'd1,
        MD_DIV_PRE = 3'd2,
        MD_DIV_IT  = 3'd3,
        MD_FIX     = 3'd4
    } md_state_e;

    // Operation kind carried by the iterative engine
    typedef enum logic [1:0] {
        MD_KIND_MUL = 2'd0,
        MD_KIND_DIV = 2'd1,
        MD_KIND_REM = 2'd2
    } md_kind_e;

    // True for codes handled by the multi-cycle engine
    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REM);
    endfunction

    // Map a multi-cycle ALU code onto the engine's operation kind
    function automatic md_kind_e code_to_kind(input logic [3:0] code);
        md_kind_e k;
        case (code)
            ALU_DIV: k = MD_KIND_DIV;
            ALU_REM: k = MD_KIND_REM;
            default: k = MD_KIND_MUL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue/result handshake between the pipeline and the execute ALU.
//   master: drives start, alu_control, op_a, op_b, flush; observes ready, valid, result, zero
//   slave : the ALU side of the same signals
interface alu_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            ready;
    logic            valid;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output start, alu_control, op_a, op_b, flush,
        input  ready, valid, result, zero
    );

    modport slave (
        input  start, alu_control, op_a, op_b, flush,
        output ready, valid, result, zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative MUL (shift-add) and signed DIV/REM (restoring) engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (only honoured in MD_IDLE)
//   kind       : MUL / DIV / REM, sampled with start
//   op_a, op_b : operands, sampled with start
//   flush      : abandon any in-flight operation
//   done_c     : high for the single FIX cycle; result_c is valid then
//   result_c   : final, sign-corrected result
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  md_kind_e        kind,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned CNTW = SHW + 1;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    md_state_e       state_q, state_d;
    md_kind_e        kind_q, kind_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    // a: multiplicand / dividend-then-quotient; b: multiplier / divisor
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    // acc: running product / partial remainder
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] orig_a_q, orig_a_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic [XLEN:0]   rem_shift_c;
    logic [XLEN:0]   diff_c;

    // State and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            kind_q    <= MD_KIND_MUL;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            orig_a_q  <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            orig_a_q  <= orig_a_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state, datapath step and final result
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        orig_a_d    = orig_a_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        done_c      = 1'b0;
        result_c    = acc_q;
        // Restoring step: shift the next dividend bit into the partial remainder
        rem_shift_c = {acc_q, a_q[XLEN-1]};
        diff_c      = rem_shift_c - {1'b0, b_q};

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    kind_d    = kind;
                    a_d       = op_a;
                    b_d       = op_b;
                    orig_a_d  = op_a;
                    acc_d     = '0;
                    cnt_d     = CNTW'(XLEN);
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    dz_d      = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = (kind == MD_KIND_MUL) ? MD_MUL_IT : MD_DIV_PRE;
                end
            end

            MD_MUL_IT: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = {a_q[XLEN-2:0], 1'b0};
                b_d   = {1'b0, b_q[XLEN-1:1]};
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = MD_FIX;
                end
            end

            MD_DIV_PRE: begin
                quo_neg_d = a_q[XLEN-1] ^ b_q[XLEN-1];
                rem_neg_d = a_q[XLEN-1];
                dz_d      = (b_q == '0);
                ovf_d     = (a_q == INT_MIN) && (b_q == ALL_ONE);
                a_d       = a_q[XLEN-1] ? (XLEN'(0) - a_q) : a_q;
                b_d       = b_q[XLEN-1] ? (XLEN'(0) - b_q) : b_q;
                acc_d     = '0;
                state_d   = MD_DIV_IT;
            end

            MD_DIV_IT: begin
                if (!diff_c[XLEN]) begin
                    acc_d = diff_c[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift_c[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = MD_FIX;
                end
            end

            MD_FIX: begin
                done_c  = 1'b1;
                state_d = MD_IDLE;
                case (kind_q)
                    MD_KIND_DIV: begin
                        if (dz_q)           result_c = ALL_ONE;
                        else if (ovf_q)     result_c = orig_a_q;
                        else if (quo_neg_q) result_c = XLEN'(0) - a_q;
                        else                result_c = a_q;
                    end
                    MD_KIND_REM: begin
                        if (dz_q)           result_c = orig_a_q;
                        else if (ovf_q)     result_c = '0;
                        else if (rem_neg_q) result_c = XLEN'(0) - acc_q;
                        else                result_c = acc_q;
                    end
                    default:                result_c = acc_q;
                endcase
            end

            default: state_d = MD_IDLE;
        endcase

        // Abort wins over any in-flight progress
        if (flush && (state_q != MD_IDLE)) begin
            state_d = MD_IDLE;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with single-cycle ops and an iterative MUL/DIV/REM engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/alu_control/op_a/op_b : issue request, sampled when ready=1
//   bus.flush  : cancel in-flight op or same-cycle start
//   bus.ready  : can accept start (low while the iterative engine is busy)
//   bus.valid  : one-cycle pulse with result/zero
//   bus.result, bus.zero : registered result and result==0
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [3:0]      ctrl_q, ctrl_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            sc_pend_q, sc_pend_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            accept_c;
    logic            md_op_c;
    logic            md_start_c;
    md_kind_e        md_kind_c;
    logic            md_done_c;
    logic [XLEN-1:0] md_result_c;
    logic [XLEN-1:0] sc_result_c;
    logic [SHW-1:0]  shamt_c;

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (md_start_c),
        .kind     (md_kind_c),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .flush    (bus.flush),
        .done_c   (md_done_c),
        .result_c (md_result_c)
    );

    // Operand latch and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            sc_pend_q <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
        end else begin
            ctrl_q    <= ctrl_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sc_pend_q <= sc_pend_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

    // Single-cycle operations on the latched operands
    always_comb begin
        shamt_c     = opb_q[SHW-1:0];
        sc_result_c = '0;
        case (ctrl_q)
            ALU_AND:  sc_result_c = opa_q & opb_q;
            ALU_OR:   sc_result_c = opa_q | opb_q;
            ALU_ADD:  sc_result_c = opa_q + opb_q;
            ALU_XOR:  sc_result_c = opa_q ^ opb_q;
            ALU_SUB:  sc_result_c = opa_q - opb_q;
            ALU_SLT:  sc_result_c = XLEN'($signed(opa_q) < $signed(opb_q));
            ALU_SLTU: sc_result_c = XLEN'(opa_q < opb_q);
            ALU_SLL:  sc_result_c = opa_q << shamt_c;
            ALU_SRL:  sc_result_c = opa_q >> shamt_c;
            ALU_SRA:  sc_result_c = XLEN'($signed(opa_q) >>> shamt_c);
            default:  sc_result_c = '0;
        endcase
    end

    // Handshake arbitration and result selection
    always_comb begin
        ctrl_d    = ctrl_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sc_pend_d = 1'b0;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;

        accept_c   = bus.start && ready_q && !bus.flush;
        md_op_c    = is_muldiv(bus.alu_control);
        md_kind_c  = code_to_kind(bus.alu_control);
        md_start_c = accept_c && md_op_c;

        if (accept_c) begin
            ctrl_d    = bus.alu_control;
            opa_d     = bus.op_a;
            opb_d     = bus.op_b;
            sc_pend_d = !md_op_c;
        end

        if (bus.flush) begin
            ready_d = 1'b1;
        end else if (md_start_c) begin
            ready_d = 1'b0;
        end else if (md_done_c) begin
            ready_d = 1'b1;
        end

        // A single-cycle result and an engine completion never share a cycle
        if (sc_pend_q) begin
            result_d = sc_result_c;
            valid_d  = 1'b1;
        end else if (md_done_c && !bus.flush) begin
            result_d = md_result_c;
            valid_d  = 1'b1;
        end

        if (valid_d) begin
            zero_d = (result_d == '0);
        end
    end

    assign bus.ready  = ready_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Issue one op and watch up to 45 cycles after the accept edge
    task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input int inject_k, output int lat, output int pulses,
                          output logic [31:0] res, output logic z,
                          output logic rdy_v, output logic rdy_busy);
        lat = -1; pulses = 0; res = '0; z = 1'b0; rdy_v = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_control = ctrl; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        rdy_busy = bus.ready;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; res = bus.result; z = bus.zero; rdy_v = bus.ready;
                end
            end
            if (k == inject_k) begin
                bus.start = 1'b1; bus.alu_control = ALU_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1;
            end else if (k == inject_k + 1) begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.alu_control = ALU_ADD; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.alu_control = ALU_SUB; bus.op_a = 32'd5; bus.op_b = 32'd5;
        @(negedge clk);
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL b2b_add_valid: got %b expected 1", bus.valid); end
        n_cmp++; if (bus.result !== 32'd4) begin n_bad++; $display("FAIL b2b_add_result: got %h expected 00000004", bus.result); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b expected 1", bus.ready); end
        bus.alu_control = ALU_SLTU; bus.op_a = 32'd1; bus.op_b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL b2b_sub_valid: got %b expected 1", bus.valid); end
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL b2b_sub_result: got %h expected 00000000", bus.result); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL b2b_sub_zero: got %b expected 1", bus.zero); end
        @(negedge clk);
        n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL b2b_sltu_valid: got %b expected 1", bus.valid); end
        n_cmp++; if (bus.result !== 32'd1) begin n_bad++; $display("FAIL b2b_sltu_result: got %h expected 00000001", bus.result); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL b2b_sltu_zero: got %b expected 0", bus.zero); end
        @(negedge clk);
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid: got %b expected 0", bus.valid); end
    endtask

    task automatic test_shifts();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        run_op(ALU_SRA, 32'h8000_0000, 32'h21, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hC000_0000) begin n_bad++; $display("FAIL sra_result: got %h expected c0000000", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sra_latency: got %0d expected 1", lat); end
        run_op(ALU_SLL, 32'h1, 32'd31, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL sll_result: got %h expected 80000000", res); end
        run_op(4'b1111, 32'h1234, 32'h5678, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL unused_result: got %h expected 00000000", res); end
        n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL unused_zero: got %b expected 1", z); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL unused_latency: got %0d expected 1", lat); end
        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd0, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'd1) begin n_bad++; $display("FAIL slt_result: got %h expected 00000001", res); end
    endtask

    task automatic test_mul();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h1) begin n_bad++; $display("FAIL mul_result: got %h expected 00000001", res); end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL mul_pulses: got %0d expected 1", pulses); end
        n_cmp++; if (rb !== 1'b0) begin n_bad++; $display("FAIL mul_ready_busy: got %b expected 0", rb); end
        n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL mul_ready_at_valid: got %b expected 1", rv); end
        run_op(ALU_MUL, 32'd3, 32'hFFFF_FFFB, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mul_neg_result: got %h expected fffffff1", res); end
    endtask

    task automatic test_div();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_result: got %h expected fffffffd", res); end
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL div_latency: got %0d expected 34", lat); end
        run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rem_result: got %h expected ffffffff", res); end
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL rem_latency: got %0d expected 34", lat); end
        run_op(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL div_pos_neg_result: got %h expected fffffff2", res); end
    endtask

    task automatic test_div_special();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        run_op(ALU_DIV, 32'd5, 32'd0, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_by_zero: got %h expected ffffffff", res); end
        n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL div_by_zero_latency: got %0d expected 34", lat); end
        run_op(ALU_REM, 32'd5, 32'd0, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'd5) begin n_bad++; $display("FAIL rem_by_zero: got %h expected 00000005", res); end
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL div_overflow: got %h expected 80000000", res); end
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL rem_overflow: got %h expected 00000000", res); end
        n_cmp++; if (z !== 1'b1) begin n_bad++; $display("FAIL rem_overflow_zero: got %b expected 1", z); end
    endtask

    task automatic test_flush();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        run_op(ALU_ADD, 32'h1000, 32'h234, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'h1234) begin n_bad++; $display("FAIL flush_pre_add: got %h expected 00001234", res); end
        @(negedge clk);
        bus.start = 1'b1; bus.alu_control = ALU_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.valid) pulses++;
            if (k == 9) begin
                n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL flush_busy_ready: got %b expected 0", bus.ready); end
            end
            if (k == 11) begin
                n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b expected 1", bus.ready); end
                bus.flush = 1'b0;
            end
            if (k == 10) bus.flush = 1'b1;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d pulses expected 0", pulses); end
        n_cmp++; if (bus.result !== 32'h1234) begin n_bad++; $display("FAIL flush_result_held: got %h expected 00001234", bus.result); end
        // Flush alongside start in idle cancels the start
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.alu_control = ALU_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL flush_cancel_valid: got %b expected 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'h1234) begin n_bad++; $display("FAIL flush_cancel_result: got %h expected 00001234", bus.result); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, pulses; logic [31:0] res; logic z, rv, rb;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_control = ALU_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b expected 1", bus.ready); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", bus.valid); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result: got %h expected 00000000", bus.result); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_bad++; $display("FAIL rst_mid_zero: got %b expected 1", bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", pulses); end
        run_op(ALU_MUL, 32'd3, 32'd5, 0, lat, pulses, res, z, rv, rb);
        n_cmp++; if (res !== 32'd15) begin n_bad++; $display("FAIL rst_recover_mul: got %h expected 0000000f", res); end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL rst_recover_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.alu_control = 4'b0000;
        bus.op_a = '0; bus.op_b = '0;
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
